// File: rtl/mo_mul_arbiter_if.sv
// Requester-side bus of the shared Montgomery multiplier arbiter.
// The arbiter uses the slave modport; the requester side uses master.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface mo_mul_arbiter_if #(
   parameter int WIDTH = `DATA_WIDTH,
   parameter int N_REQ = 4,
   parameter int LAT   = WIDTH + 1
);
   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0][WIDTH-1:0]  req_a;
   logic [N_REQ-1:0][WIDTH-1:0]  req_b;
   logic [N_REQ-1:0]             req_ready;
   logic [N_REQ-1:0]             resp_valid;
   logic [WIDTH-1:0]             resp_data;
   logic [$clog2(LAT+1)-1:0]     inflight;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_data, inflight
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_data, inflight
   );
endinterface

// File: rtl/mo_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined Montgomery multiplier
// (a*b*2^-WIDTH mod Q) among N_REQ requesters. A tag pipeline running in
// lockstep with the multiplier routes each result back to its issuer.
// The multiplier is radix-2, one operand-a bit per stage, followed by a
// single conditional subtraction, so results always land in 0..Q-1.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module mo_mul_arbiter #(
   parameter int WIDTH = `DATA_WIDTH,
   parameter int N_REQ = 4,
   parameter int Q     = 3329
) (
   input  logic              clk,
   input  logic              rst_n,
   mo_mul_arbiter_if.slave   bus
);
   // Input register + WIDTH reduction stages; the output register adds one more.
   localparam int LAT = WIDTH + 1;
   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(LAT + 1);
   localparam int TW  = WIDTH + 1;   // partial result < 2Q
   localparam int SW  = WIDTH + 2;   // partial sum before halving < 4Q

   // Index of the k-th candidate counted from the round-robin pointer.
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      return IDW'(sum % N_REQ);
   endfunction

   // One radix-2 Montgomery step: t' = (t + a_bit*b + q*Q) / 2, q chosen to make the sum even.
   function automatic logic [TW-1:0] mont_step(input logic [TW-1:0] t,
                                               input logic a_bit,
                                               input logic [WIDTH-1:0] b);
      logic [SW-1:0] s;
      s = {1'b0, t} + (a_bit ? {2'b00, b} : {SW{1'b0}});
      if (s[0]) begin
         s = s + SW'(Q);
      end else begin
         s = s;
      end
      return s[SW-1:1];
   endfunction

   // Bring a partial result < 2Q into 0..Q-1.
   function automatic logic [WIDTH-1:0] final_reduce(input logic [TW-1:0] t);
      logic [TW-1:0] d;
      if (t >= TW'(Q)) begin
         d = t - TW'(Q);
      end else begin
         d = t;
      end
      return d[WIDTH-1:0];
   endfunction

   logic [IDW-1:0]              ptr_r;
   logic [IDW-1:0]              gid_s;
   logic                        grant_s;
   logic [N_REQ-1:0]            ready_s;
   logic [WIDTH-1:0]            mux_a_s;
   logic [WIDTH-1:0]            mux_b_s;

   logic [WIDTH-1:0]            a_p [WIDTH];
   logic [WIDTH-1:0]            b_p [WIDTH];
   logic [TW-1:0]               t_p [1:WIDTH];

   logic [LAT-1:0]              tag_vld_r;
   logic [LAT-1:0][IDW-1:0]     tag_id_r;
   logic [N_REQ-1:0]            resp_valid_r;
   logic [WIDTH-1:0]            resp_data_r;
   logic [CW-1:0]               inflight_r;

   // Round-robin search from ptr_r; the winner's operands go straight to the multiplier.
   always_comb begin
      ready_s = '0;
      grant_s = 1'b0;
      gid_s   = '0;
      mux_a_s = '0;
      mux_b_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_s && bus.req_valid[rr_index(ptr_r, k)]) begin
            grant_s = 1'b1;
            gid_s   = rr_index(ptr_r, k);
         end else begin
            grant_s = grant_s;
         end
      end
      if (grant_s) begin
         ready_s[gid_s] = 1'b1;
         mux_a_s        = bus.req_a[gid_s];
         mux_b_s        = bus.req_b[gid_s];
      end else begin
         ready_s = '0;
      end
   end

   // Pointer moves past the last winner; idle cycles leave it in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (grant_s) begin
         ptr_r <= (gid_s == IDW'(N_REQ - 1)) ? '0 : gid_s + IDW'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Multiplier datapath; left unreset because the tag pipeline qualifies every result.
   always_ff @(posedge clk) begin
      a_p[0] <= mux_a_s;
      b_p[0] <= mux_b_s;
      t_p[1] <= mont_step({TW{1'b0}}, a_p[0][0], b_p[0]);
      for (int i = 1; i < WIDTH; i++) begin
         a_p[i]   <= a_p[i-1];
         b_p[i]   <= b_p[i-1];
         t_p[i+1] <= mont_step(t_p[i], a_p[i][i], b_p[i]);
      end
   end

   // Tag shift register plus aligned output registers for the returning result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_r    <= '0;
         tag_id_r     <= '0;
         resp_valid_r <= '0;
         resp_data_r  <= '0;
      end else begin
         tag_vld_r   <= {tag_vld_r[LAT-2:0], grant_s};
         tag_id_r    <= {tag_id_r[LAT-2:0], gid_s};
         resp_data_r <= final_reduce(t_p[WIDTH]);
         if (tag_vld_r[LAT-1]) begin
            resp_valid_r <= N_REQ'(1) << tag_id_r[LAT-1];
         end else begin
            resp_valid_r <= '0;
         end
      end
   end

   // Outstanding-operation count: up on accept, down when a result is presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_r <= '0;
      end else begin
         inflight_r <= inflight_r + CW'(grant_s) - CW'(tag_vld_r[LAT-1]);
      end
   end

   assign bus.req_ready  = ready_s;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_data  = resp_data_r;
   assign bus.inflight   = inflight_r;

endmodule

// File: tb/tb_mo_mul_arbiter.sv
// Randomized bench for mo_mul_arbiter with a queue-based reference model.
module tb_mo_mul_arbiter;
   localparam int WIDTH = 12;
   localparam int N_REQ = 4;
   localparam int LAT   = WIDTH + 1;
   localparam int Q     = 3329;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mo_mul_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LAT(LAT)) ifc ();

   mo_mul_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .Q(Q)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   typedef struct {
      int due;
      int id;
      int a;
      int b;
   } op_t;

   op_t sb[$];
   op_t cur;
   int  ord[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc   = 0;
   int  rinv  = 0;
   int  ptr_m = 0;
   int  exp_g;
   int  exp_rv;
   int  exp_ready;
   int  nacc_tot;
   int  norm;
   int  gcnt [N_REQ];
   int  op_a [N_REQ];
   int  op_b [N_REQ];

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // a*b*2^-12 mod Q computed with plain modular arithmetic.
   function automatic int mont_ref(input int a, input int b);
      return (((a * b) % Q) * rinv) % Q;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: predicts grants, responses and the in-flight count at each negedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         ptr_m = 0;
         check_eq("rst_resp_valid", int'(ifc.resp_valid), 0);
         check_eq("rst_inflight", int'(ifc.inflight), 0);
      end else begin
         while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
         exp_rv = 0;
         if (sb.size() > 0 && sb[0].due == cyc) exp_rv = 1 << sb[0].id;
         check_eq("resp_valid", int'(ifc.resp_valid), exp_rv);
         if (exp_rv != 0) begin
            cur  = sb.pop_front();
            norm = (int'(ifc.resp_data) == Q) ? 0 : int'(ifc.resp_data);
            check_eq("resp_data", norm, mont_ref(cur.a, cur.b));
         end
         check_eq("inflight", int'(ifc.inflight), sb.size());
         check_eq("inflight_le_lat", int'(int'(ifc.inflight) <= LAT), 1);
         exp_g = -1;
         for (int k = 0; k < N_REQ; k++)
            if (exp_g < 0 && ifc.req_valid[(ptr_m + k) % N_REQ]) exp_g = (ptr_m + k) % N_REQ;
         exp_ready = (exp_g < 0) ? 0 : (1 << exp_g);
         check_eq("req_ready", int'(ifc.req_ready), exp_ready);
         if (exp_g >= 0 && (ifc.req_ready & ifc.req_valid) != '0) begin
            cur.due = cyc + 1 + LAT;
            cur.id  = exp_g;
            cur.a   = int'(ifc.req_a[exp_g]);
            cur.b   = int'(ifc.req_b[exp_g]);
            sb.push_back(cur);
            gcnt[exp_g]++;
            ptr_m = (exp_g + 1) % N_REQ;
         end
      end
   end

   task automatic new_ops(input int i);
      ifc.req_a[i] = WIDTH'($urandom_range(Q - 1));
      ifc.req_b[i] = WIDTH'($urandom_range(Q));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the masked requesters valid with op_a/op_b until each is accepted.
   task automatic drain(input logic [N_REQ-1:0] mask);
      logic [N_REQ-1:0] acc;
      for (int i = 0; i < N_REQ; i++) begin
         ifc.req_a[i] = WIDTH'(op_a[i]);
         ifc.req_b[i] = WIDTH'(op_b[i]);
      end
      ifc.req_valid = mask;
      for (int n = 0; n < 20 && ifc.req_valid != '0; n++) begin
         @(negedge clk);
         acc = ifc.req_valid & ifc.req_ready;
         for (int i = 0; i < N_REQ; i++) if (acc[i]) ord.push_back(i);
         @(posedge clk);
         #1;
         ifc.req_valid = ifc.req_valid & ~acc;
      end
      check_eq("drain_done", int'(ifc.req_valid), 0);
      ifc.req_valid = '0;
   endtask

   // Random valid/ready traffic; pct is the chance a free requester raises valid.
   task automatic traffic(input int pct, input int max_cyc, input int target);
      logic [N_REQ-1:0] acc;
      int nacc;
      nacc = 0;
      for (int i = 0; i < N_REQ; i++) begin
         ifc.req_valid[i] = ($urandom_range(99) < pct);
         new_ops(i);
      end
      for (int n = 0; n < max_cyc && nacc < target; n++) begin
         @(negedge clk);
         acc  = ifc.req_valid & ifc.req_ready;
         nacc += $countones(acc);
         @(posedge clk);
         #1;
         for (int i = 0; i < N_REQ; i++) begin
            if (!ifc.req_valid[i] || acc[i]) begin
               ifc.req_valid[i] = ($urandom_range(99) < pct);
               new_ops(i);
            end
         end
      end
      nacc_tot = nacc;
   endtask

   // Let pending requests complete without raising new ones.
   task automatic quiesce();
      logic [N_REQ-1:0] acc;
      for (int n = 0; n < 20 && ifc.req_valid != '0; n++) begin
         @(negedge clk);
         acc = ifc.req_valid & ifc.req_ready;
         @(posedge clk);
         #1;
         ifc.req_valid = ifc.req_valid & ~acc;
      end
      check_eq("quiesce", int'(ifc.req_valid), 0);
      ifc.req_valid = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int x = 1; x < Q; x++) if ((((1 << WIDTH) % Q) * x) % Q == 1) rinv = x;
      for (int i = 0; i < N_REQ; i++) gcnt[i] = 0;
      ifc.req_valid = '0;
      ifc.req_a     = '0;
      ifc.req_b     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset: nothing granted, nothing returned.
      idle(20);
      check_eq("idle_resp_data", int'(ifc.resp_data), 0);

      // Single requester 1: 767 * 5 * 2^-12 = 5 mod Q.
      op_a[1] = 767;
      op_b[1] = 5;
      drain(4'b0010);
      idle(LAT + 2);

      // All requesters valid: strict rotation, ten grants each over forty cycles.
      for (int i = 0; i < N_REQ; i++) gcnt[i] = 0;
      traffic(100, 40, 1000);
      for (int i = 0; i < N_REQ; i++) check_eq("rotation_count", gcnt[i], 10);
      quiesce();
      idle(LAT + 2);

      // Pointer at 3 with requesters 0 and 2 pending: 0 wins first; a=0 gives 0.
      op_a[2] = int'($urandom_range(Q - 1));
      op_b[2] = int'($urandom_range(Q));
      drain(4'b0100);
      ord.delete();
      op_a[0] = 0;
      op_b[0] = int'($urandom_range(Q));
      op_a[2] = 0;
      op_b[2] = int'($urandom_range(Q));
      drain(4'b0101);
      check_eq("wrap_order_len", ord.size(), 2);
      if (ord.size() == 2) begin
         check_eq("wrap_first", ord[0], 0);
         check_eq("wrap_second", ord[1], 2);
      end
      idle(LAT + 2);

      // Random traffic with gaps until 100 accepts.
      traffic(60, 2000, 100);
      check_eq("random_accepts", int'(nacc_tot >= 100), 1);
      quiesce();
      idle(LAT + 3);
      check_eq("random_drained", sb.size(), 0);

      // Five ops in flight, one-cycle reset, then a fresh op.
      for (int i = 0; i < N_REQ; i++) begin
         op_a[i] = int'($urandom_range(Q - 1));
         op_b[i] = int'($urandom_range(Q));
      end
      drain(4'b1111);
      drain(4'b0100);
      idle(2);
      ifc.req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_eq("post_rst_inflight", int'(ifc.inflight), 0);
      idle(LAT + 5);
      ord.delete();
      drain(4'b1001);
      check_eq("post_rst_order_len", ord.size(), 2);
      if (ord.size() == 2) begin
         check_eq("post_rst_first", ord[0], 0);
         check_eq("post_rst_second", ord[1], 3);
      end
      idle(LAT + 3);
      check_eq("post_rst_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
